// File: rtl/rr_sched4x1.sv
// Four-lane round-robin scheduler: each lane buffers up to two words in a small FIFO,
// and a registered output stage drains the lanes one word per handshake.
module rr_sched4x1 #(
  parameter int unsigned DW = 4
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic [3:0]    valid_in,
  input  logic [DW-1:0] data_in0,
  input  logic [DW-1:0] data_in1,
  input  logic [DW-1:0] data_in2,
  input  logic [DW-1:0] data_in3,
  output logic [3:0]    ready_out,
  input  logic          ready_in,
  output logic          valid_out,
  output logic [DW-1:0] data_out,
  output logic [1:0]    selector
);

  logic [DW-1:0] din [4];
  logic [DW-1:0] mem_q [4][2];
  logic [1:0]    cnt_q [4];
  logic [3:0]    rd_q;
  logic [3:0]    wr_q;
  logic [1:0]    ptr_q;

  logic [3:0] push;
  logic [3:0] pop;
  logic [3:0] nonempty;
  logic       load;
  logic       gnt_valid;
  logic [1:0] gnt_idx;
  logic [1:0] idx;

  assign din[0] = data_in0;
  assign din[1] = data_in1;
  assign din[2] = data_in2;
  assign din[3] = data_in3;

  assign load = !valid_out || ready_in;

  // ready_out depends only on registered occupancy, never on valid_in or ready_in.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      ready_out[i] = (cnt_q[i] < 2'd2);
      nonempty[i]  = (cnt_q[i] != 2'd0);
      push[i]      = valid_in[i] && ready_out[i];
    end
  end

  // First non-empty lane at or after ptr_q, wrapping modulo 4.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = 2'd0;
    idx       = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!gnt_valid && nonempty[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pop[i] = load && gnt_valid && (gnt_idx == 2'(i));
    end
  end

  // Payload storage needs no reset; occupancy counts define what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (push[i]) begin
        mem_q[i][wr_q[i]] <= din[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= 2'd0;
      end
      rd_q      <= 4'd0;
      wr_q      <= 4'd0;
      ptr_q     <= 2'd0;
      valid_out <= 1'b0;
      data_out  <= '0;
      selector  <= 2'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (push[i]) begin
          wr_q[i] <= ~wr_q[i];
        end
        if (pop[i]) begin
          rd_q[i] <= ~rd_q[i];
        end
        case ({push[i], pop[i]})
          2'b10:   cnt_q[i] <= cnt_q[i] + 2'd1;
          2'b01:   cnt_q[i] <= cnt_q[i] - 2'd1;
          default: cnt_q[i] <= cnt_q[i];
        endcase
      end
      if (load) begin
        if (gnt_valid) begin
          valid_out <= 1'b1;
          data_out  <= mem_q[gnt_idx][rd_q[gnt_idx]];
          selector  <= gnt_idx;
          ptr_q     <= gnt_idx + 2'd1;
        end else begin
          valid_out <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rr_sched4x1.sv
// Directed, table-driven bench for rr_sched4x1 with hand-computed expectations.
module tb_rr_sched4x1;

  localparam int unsigned DW = 4;

  logic          clk;
  logic          reset_L;
  logic [3:0]    valid_in;
  logic [DW-1:0] data_in0, data_in1, data_in2, data_in3;
  logic [3:0]    ready_out;
  logic          ready_in;
  logic          valid_out;
  logic [DW-1:0] data_out;
  logic [1:0]    selector;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] vin;
    logic [3:0] d0;
    logic [3:0] d1;
    logic [3:0] d2;
    logic [3:0] d3;
    logic       rin;
    logic       ev;
    logic [3:0] ed;
    logic [1:0] es;
    logic [3:0] er;
  } vec_t;

  rr_sched4x1 #(.DW(DW)) dut (
    .clk       (clk),
    .reset_L   (reset_L),
    .valid_in  (valid_in),
    .data_in0  (data_in0),
    .data_in1  (data_in1),
    .data_in2  (data_in2),
    .data_in3  (data_in3),
    .ready_out (ready_out),
    .ready_in  (ready_in),
    .valid_out (valid_out),
    .data_out  (data_out),
    .selector  (selector)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input logic [3:0] vin, input logic [3:0] d0, input logic [3:0] d1,
                              input logic [3:0] d2, input logic [3:0] d3, input logic rin,
                              input logic ev, input logic [3:0] ed, input logic [1:0] es,
                              input logic [3:0] er);
    vec_t v;
    v.vin = vin; v.d0 = d0; v.d1 = d1; v.d2 = d2; v.d3 = d3; v.rin = rin;
    v.ev = ev; v.ed = ed; v.es = es; v.er = er;
    return v;
  endfunction

  task automatic check(input string tag, input logic ev, input logic [3:0] ed,
                       input logic [1:0] es, input logic [3:0] er);
    checks++;
    if ({valid_out, data_out, selector, ready_out} !== {ev, ed, es, er}) begin
      errors++;
      $display("FAIL %s: got valid=%0b data=%h sel=%0d ready=%b, want valid=%0b data=%h sel=%0d ready=%b",
               tag, valid_out, data_out, selector, ready_out, ev, ed, es, er);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    valid_in = v.vin;
    data_in0 = v.d0;
    data_in1 = v.d1;
    data_in2 = v.d2;
    data_in3 = v.d3;
    ready_in = v.rin;
    @(posedge clk);
    #1;
    check(tag, v.ev, v.ed, v.es, v.er);
  endtask

  vec_t tbl[$];
  vec_t seq[$];

  initial begin
    // Round robin from reset: lanes 0..3 hold words {1,2},{3,4},{5,6},{7,8}.
    tbl.push_back(mk(4'b1111, 4'h1, 4'h3, 4'h5, 4'h7, 0, 0, 4'h0, 0, 4'b1111));
    tbl.push_back(mk(4'b1111, 4'h2, 4'h4, 4'h6, 4'h8, 0, 1, 4'h1, 0, 4'b0001));
    tbl.push_back(mk(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1, 1, 4'h3, 1, 4'b0011));
    tbl.push_back(mk(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1, 1, 4'h5, 2, 4'b0111));
    tbl.push_back(mk(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1, 1, 4'h7, 3, 4'b1111));
    tbl.push_back(mk(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1, 1, 4'h2, 0, 4'b1111));
    tbl.push_back(mk(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1, 1, 4'h4, 1, 4'b1111));
    tbl.push_back(mk(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1, 1, 4'h6, 2, 4'b1111));
    tbl.push_back(mk(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1, 1, 4'h8, 3, 4'b1111));
    tbl.push_back(mk(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0, 4'h8, 3, 4'b1111));
    // Single word on lane 2: visible one edge after the push, then idle.
    tbl.push_back(mk(4'b0100, 4'h0, 4'h0, 4'hA, 4'h0, 1, 0, 4'h8, 3, 4'b1111));
    tbl.push_back(mk(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1, 1, 4'hA, 2, 4'b1111));
    tbl.push_back(mk(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0, 4'hA, 2, 4'b1111));
    // Backpressure on lane 1: fill, refuse word 4, then drain in order.
    tbl.push_back(mk(4'b0010, 4'h0, 4'h1, 4'h0, 4'h0, 0, 0, 4'hA, 2, 4'b1111));
    tbl.push_back(mk(4'b0010, 4'h0, 4'h2, 4'h0, 4'h0, 0, 1, 4'h1, 1, 4'b1111));
    tbl.push_back(mk(4'b0010, 4'h0, 4'h3, 4'h0, 4'h0, 0, 1, 4'h1, 1, 4'b1101));
    tbl.push_back(mk(4'b0010, 4'h0, 4'h4, 4'h0, 4'h0, 0, 1, 4'h1, 1, 4'b1101));
    tbl.push_back(mk(4'b0010, 4'h0, 4'h4, 4'h0, 4'h0, 1, 1, 4'h2, 1, 4'b1111));
    tbl.push_back(mk(4'b0010, 4'h0, 4'h4, 4'h0, 4'h0, 1, 1, 4'h3, 1, 4'b1111));
    tbl.push_back(mk(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1, 1, 4'h4, 1, 4'b1111));
    tbl.push_back(mk(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0, 4'h4, 1, 4'b1111));
    // Fairness: move ptr to 3 via lane 2, then lanes 3 and 0 alternate.
    tbl.push_back(mk(4'b0100, 4'h0, 4'h0, 4'h9, 4'h0, 1, 0, 4'h4, 1, 4'b1111));
    tbl.push_back(mk(4'b1001, 4'h1, 4'h0, 4'h0, 4'h5, 1, 1, 4'h9, 2, 4'b1111));
    tbl.push_back(mk(4'b1001, 4'h2, 4'h0, 4'h0, 4'h6, 1, 1, 4'h5, 3, 4'b1110));
    tbl.push_back(mk(4'b1001, 4'h3, 4'h0, 4'h0, 4'h7, 1, 1, 4'h1, 0, 4'b0111));
    tbl.push_back(mk(4'b1001, 4'h3, 4'h0, 4'h0, 4'h8, 1, 1, 4'h6, 3, 4'b1110));
    tbl.push_back(mk(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1, 1, 4'h2, 0, 4'b1111));
    tbl.push_back(mk(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1, 1, 4'h7, 3, 4'b1111));
    tbl.push_back(mk(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1, 1, 4'h3, 0, 4'b1111));
    tbl.push_back(mk(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0, 4'h3, 0, 4'b1111));
    // Same-lane push and pop on lane 0.
    tbl.push_back(mk(4'b0001, 4'hB, 4'h0, 4'h0, 4'h0, 1, 0, 4'h3, 0, 4'b1111));
    tbl.push_back(mk(4'b0001, 4'hC, 4'h0, 4'h0, 4'h0, 1, 1, 4'hB, 0, 4'b1111));
    tbl.push_back(mk(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1, 1, 4'hC, 0, 4'b1111));
    tbl.push_back(mk(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0, 4'hC, 0, 4'b1111));
    // Load all lanes and stall a word on the output ahead of a reset.
    tbl.push_back(mk(4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 0, 0, 4'hC, 0, 4'b1111));
    tbl.push_back(mk(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 0, 1, 4'h2, 1, 4'b1111));

    reset_L  = 1'b0;
    valid_in = 4'b1111;
    data_in0 = 4'h5;
    data_in1 = 4'h6;
    data_in2 = 4'h7;
    data_in3 = 4'h8;
    ready_in = 1'b1;
    #3;
    check("reset_state", 0, 4'h0, 0, 4'b1111);
    @(posedge clk);
    #1;
    check("reset_push_ignored", 0, 4'h0, 0, 4'b1111);
    reset_L = 1'b1;

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // Asynchronous reset with a word pending and every lane non-empty.
    reset_L = 1'b0;
    #1;
    check("async_reset", 0, 4'h0, 0, 4'b1111);
    valid_in = 4'b1111;
    ready_in = 1'b1;
    @(posedge clk);
    #1;
    check("reset_hold", 0, 4'h0, 0, 4'b1111);
    reset_L = 1'b1;
    seq.push_back(mk(4'b1000, 4'h0, 4'h0, 4'h0, 4'hD, 1, 0, 4'h0, 0, 4'b1111));
    seq.push_back(mk(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1, 1, 4'hD, 3, 4'b1111));
    seq.push_back(mk(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0, 4'hD, 3, 4'b1111));
    // Leave ptr at 2 before the next reset.
    seq.push_back(mk(4'b0010, 4'h0, 4'h6, 4'h0, 4'h0, 1, 0, 4'hD, 3, 4'b1111));
    seq.push_back(mk(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1, 1, 4'h6, 1, 4'b1111));
    foreach (seq[i]) apply(seq[i], $sformatf("post_reset%0d", i));

    // After reset the search must restart at lane 0, not lane 2.
    reset_L = 1'b0;
    #2;
    check("reset_pulse", 0, 4'h0, 0, 4'b1111);
    reset_L = 1'b1;
    seq.delete();
    seq.push_back(mk(4'b1001, 4'h7, 4'h0, 4'h0, 4'h8, 1, 0, 4'h0, 0, 4'b1111));
    seq.push_back(mk(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1, 1, 4'h7, 0, 4'b1111));
    seq.push_back(mk(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1, 1, 4'h8, 3, 4'b1111));
    seq.push_back(mk(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0, 4'h8, 3, 4'b1111));
    foreach (seq[i]) apply(seq[i], $sformatf("ptr_reset%0d", i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
